ps2_keyboard_rx: RTL and testbench
==================================

PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, as listed in REQ-004 and REQ-005.
REQ-002 Parameter FILTER_LEN SHALL default to 8 and set the number of consecutive equal ps2_clk samples needed to change the filtered clock.
REQ-003 Parameter TIMEOUT_CYCLES SHALL default to 50000 (1 ms at 50 MHz) and set the maximum number of clk cycles between filtered falling edges within one frame.
REQ-004 Port clk SHALL be an input, 1 bit wide: the system clock, with all logic on its rising edge.
REQ-005 Port reset_n SHALL be an input, 1 bit wide: asynchronous active-low reset.
REQ-006 Port ps2_clk SHALL be an input, 1 bit wide: raw, asynchronous PS/2 device clock.
REQ-007 Port ps2_dat SHALL be an input, 1 bit wide: raw, asynchronous PS/2 device data.
REQ-008 Port keyboard_code SHALL be an output, 8 bits wide: last reported scan code; it drives the keyboard PIO.
REQ-009 Port code_rdy SHALL be an output, 8 bits wide: status word that drives the code-ready PIO (REQ-021).
REQ-010 Port code_valid SHALL be an output, 1 bit wide: one-cycle pulse when keyboard_code/code_rdy update.
REQ-011 Port frame_err SHALL be an output, 1 bit wide: one-cycle pulse on each rejected frame.

Function
REQ-012 ps2_clk and ps2_dat SHALL each pass through a 2-flop synchronizer before any use; the synchronizer flops reset to 1.
REQ-013 Filter: ps2_clk_f SHALL go to 1 after FILTER_LEN consecutive synchronized 1s, go to 0 after FILTER_LEN consecutive 0s, and otherwise hold; its reset value is 1.
REQ-014 A falling edge of ps2_clk_f SHALL be the only bit-sample event, and bits SHALL be sampled from the synchronized ps2_dat.
REQ-015 FSM states SHALL be IDLE, DATA, PARITY and STOP, with a 3-bit data bit counter.
REQ-016 IDLE: on a sample of 0 (start bit) -> DATA with counter=0; a sample of 1 is ignored and the FSM stays in IDLE.
REQ-017 DATA: each sample SHALL shift in LSB first; after the 8th bit -> PARITY.
REQ-018 PARITY: the sample SHALL be stored; -> STOP.
REQ-019 STOP: the frame is valid when the stop bit is 1 and the 8 data bits plus the parity bit have an odd count of ones; in either case -> IDLE.
REQ-020 Valid frame: byte 0xF0 SHALL set break_pend and byte 0xE0 SHALL set ext_pend, with no output update for either; any other byte SHALL be reported.
REQ-021 On report, in the cycle after the stop-bit sample:
- keyboard_code = byte;
- code_rdy[0] toggles;
- code_rdy[1] = break_pend;
- code_rdy[2] = ext_pend;
- code_rdy[3] = 0;
- code_valid = 1 for one cycle;
- break_pend and ext_pend clear.
REQ-022 code_rdy[7:4] SHALL be constant 0.
REQ-023 Invalid frame (bad parity or stop=0): keyboard_code and code_rdy[2:0] SHALL hold, code_rdy[3] = 1 (sticky until the next report), frame_err pulses once, and break_pend/ext_pend clear.
REQ-024 Timeout: in any non-IDLE state, if TIMEOUT_CYCLES clk cycles elapse with no filtered falling edge, the FSM SHALL go to IDLE, discard partial data, pulse frame_err and set code_rdy[3]; the timeout counter resets on every falling edge and while in IDLE.
REQ-025 A falling edge in the same cycle the timeout expires SHALL be treated as a timeout; the edge is discarded.
REQ-026 Back-to-back frames SHALL be accepted with no dead time beyond the IDLE re-entry cycle.

Reset
REQ-027 While reset_n = 0 the block SHALL hold: keyboard_code=0x00, code_rdy=0x00, code_valid=0, frame_err=0, FSM=IDLE, counters=0, break_pend=ext_pend=0, and the filter output and synchronizer flops at 1.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with no pulse; after release the next start bit begins a fresh frame.

Verification
REQ-029 Frame 0x1C (parity bit 0, stop 1) -> keyboard_code=0x1C, code_rdy=0x01, one code_valid pulse.
REQ-030 Frames F0 then 1C -> one code_valid only, after 1C; keyboard_code=0x1C, code_rdy[1]=1, code_rdy[0] toggled.
REQ-031 Frames E0, F0, 75 -> keyboard_code=0x75, code_rdy[2:1]=11, a single code_valid.
REQ-032 Frame 0x1C with parity bit 1 -> no code_valid, frame_err pulse, code_rdy[3]=1, keyboard_code unchanged; a following valid 0x29 -> code_rdy[3]=0, keyboard_code=0x29.
REQ-033 Start + 4 data bits, then ps2_clk held high -> frame_err pulse exactly TIMEOUT_CYCLES after the last edge; a following full 0x1C frame decodes correctly.
REQ-034 Glitches on ps2_clk shorter than FILTER_LEN cycles during a frame -> no extra bit sampled, correct code reported; reset_n pulsed mid-frame -> all outputs 0, and the next frame decodes.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver.
// Synchronizes and de-glitches the raw PS/2 clock, decodes 11-bit device
// frames (start, 8 data LSB first, odd parity, stop), folds the 0xF0 (break)
// and 0xE0 (extended) prefixes into status bits, and reports each finished
// scan code through registered PIO-style outputs.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] keyboard_code,
    output logic [7:0] code_rdy,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // True when the data byte plus its parity bit carry an odd number of ones.
    function automatic logic odd_ones(input logic [8:0] v);
        odd_ones = ^v;
    endfunction

    logic          clk_s1_r, clk_s2_r, dat_s1_r, dat_s2_r;
    logic [FW-1:0] filt_cnt_r;
    logic          clk_f_r, clk_f_d_r;
    logic          fall_s;
    state_t        state_r, state_n;
    logic [2:0]    bit_cnt_r, bit_cnt_n;
    logic [7:0]    shift_r, shift_n;
    logic          par_r, par_n;
    logic [TW-1:0] tmo_cnt_r;
    logic          expire_s, good_s, bad_s, tmo_s;
    logic          break_pend_r, ext_pend_r;
    logic [7:0]    code_r;
    logic [3:0]    rdy_r;
    logic          valid_r, err_r;

    // Two-flop synchronizers for the asynchronous PS/2 lines; idle level is 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_r <= 1'b1;
            clk_s2_r <= 1'b1;
            dat_s1_r <= 1'b1;
            dat_s2_r <= 1'b1;
        end else begin
            clk_s1_r <= ps2_clk;
            clk_s2_r <= clk_s1_r;
            dat_s1_r <= ps2_dat;
            dat_s2_r <= dat_s1_r;
        end
    end

    // Clock filter: flip only after FILTER_LEN consecutive opposite samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_cnt_r <= {FW{1'b0}};
            clk_f_r    <= 1'b1;
            clk_f_d_r  <= 1'b1;
        end else begin
            clk_f_d_r <= clk_f_r;
            if (clk_s2_r == clk_f_r) begin
                filt_cnt_r <= {FW{1'b0}};
            end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
                filt_cnt_r <= {FW{1'b0}};
                clk_f_r    <= clk_s2_r;
            end else begin
                filt_cnt_r <= filt_cnt_r + 1'b1;
            end
        end
    end

    assign fall_s   = clk_f_d_r & ~clk_f_r;
    assign expire_s = (state_r != IDLE) && (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));

    // Frame FSM next state; a timeout wins over a coincident clock edge.
    always_comb begin
        state_n   = state_r;
        bit_cnt_n = bit_cnt_r;
        shift_n   = shift_r;
        par_n     = par_r;
        good_s    = 1'b0;
        bad_s     = 1'b0;
        tmo_s     = 1'b0;
        if (expire_s) begin
            state_n   = IDLE;
            bit_cnt_n = 3'd0;
            shift_n   = 8'h00;
            tmo_s     = 1'b1;
        end else if (fall_s) begin
            case (state_r)
                IDLE: begin
                    if (!dat_s2_r) begin
                        state_n   = DATA;
                        bit_cnt_n = 3'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                DATA: begin
                    shift_n = {dat_s2_r, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        state_n   = PARITY;
                        bit_cnt_n = 3'd0;
                    end else begin
                        bit_cnt_n = bit_cnt_r + 3'd1;
                    end
                end
                PARITY: begin
                    par_n   = dat_s2_r;
                    state_n = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (dat_s2_r && odd_ones({shift_r, par_r})) begin
                        good_s = 1'b1;
                    end else begin
                        bad_s = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // FSM and frame datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            par_r     <= 1'b0;
        end else begin
            state_r   <= state_n;
            bit_cnt_r <= bit_cnt_n;
            shift_r   <= shift_n;
            par_r     <= par_n;
        end
    end

    // Inter-edge watchdog: cleared in IDLE and on every filtered falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (state_r == IDLE || fall_s || expire_s) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
        end
    end

    // Prefix tracking and registered reporting of codes and errors.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            break_pend_r <= 1'b0;
            ext_pend_r   <= 1'b0;
            code_r       <= 8'h00;
            rdy_r        <= 4'h0;
            valid_r      <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            if (good_s) begin
                if (shift_r == 8'hF0) begin
                    break_pend_r <= 1'b1;
                end else if (shift_r == 8'hE0) begin
                    ext_pend_r <= 1'b1;
                end else begin
                    code_r       <= shift_r;
                    rdy_r        <= {1'b0, ext_pend_r, break_pend_r, ~rdy_r[0]};
                    valid_r      <= 1'b1;
                    break_pend_r <= 1'b0;
                    ext_pend_r   <= 1'b0;
                end
            end else if (bad_s) begin
                rdy_r[3]     <= 1'b1;
                err_r        <= 1'b1;
                break_pend_r <= 1'b0;
                ext_pend_r   <= 1'b0;
            end else if (tmo_s) begin
                rdy_r[3] <= 1'b1;
                err_r    <= 1'b1;
            end else begin
                rdy_r <= rdy_r;
            end
        end
    end

    assign keyboard_code = code_r;
    assign code_rdy      = {4'h0, rdy_r};
    assign code_valid    = valid_r;
    assign frame_err     = err_r;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed vectors, timeout,
// glitch/reset handling and randomized frames against a behavioural model.
module tb_ps2_keyboard_rx;

    localparam int F = 8;
    localparam int T = 400;
    localparam int H = 24;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] keyboard_code;
    logic [7:0] code_rdy;
    logic       code_valid;
    logic       frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    // observed pulse bookkeeping
    int cyc = 0;
    int d_nvalid = 0;
    int d_nerr = 0;
    int last_valid_cyc = 0;
    int last_err_cyc = 0;
    int fall_cyc = 0;

    // behavioural model state
    logic [7:0] m_code = 8'h00;
    logic [3:0] m_rdy = 4'h0;
    logic       m_brk = 1'b0;
    logic       m_ext = 1'b0;
    int         m_nvalid = 0;
    int         m_nerr = 0;

    ps2_keyboard_rx #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .keyboard_code(keyboard_code), .code_rdy(code_rdy),
        .code_valid(code_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitor
    always @(negedge clk) begin
        if (reset_n && code_valid) begin
            d_nvalid <= d_nvalid + 1;
            last_valid_cyc <= cyc;
        end
        if (reset_n && frame_err) begin
            d_nerr <= d_nerr + 1;
            last_err_cyc <= cyc;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data set while clock high, device pulls clock low for H/2+H/2.
    task automatic send_bit(input logic b, input bit glitch);
        ps2_dat = b;
        if (glitch) begin
            wait_cyc(H / 2); ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1; wait_cyc(H / 2 - 3);
        end else begin
            wait_cyc(H);
        end
        ps2_clk = 1'b0;
        fall_cyc = cyc;
        if (glitch) begin
            wait_cyc(H / 2); ps2_clk = 1'b1; wait_cyc(2); ps2_clk = 1'b0; wait_cyc(H / 2 - 2);
        end else begin
            wait_cyc(H);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch);
        logic par;
        par = (~^b) ^ bad_par;
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
        send_bit(par, glitch);
        send_bit(~bad_stop, glitch);
        ps2_dat = 1'b1;
        wait_cyc(H);
    endtask

    // Reference behaviour of one complete frame.
    task automatic model_frame(input logic [7:0] b, input bit good);
        if (good) begin
            if (b == 8'hF0) m_brk = 1'b1;
            else if (b == 8'hE0) m_ext = 1'b1;
            else begin
                m_code = b;
                m_rdy = {1'b0, m_ext, m_brk, ~m_rdy[0]};
                m_nvalid++;
                m_brk = 1'b0;
                m_ext = 1'b0;
            end
        end else begin
            m_rdy[3] = 1'b1;
            m_nerr++;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_code = 8'h00; m_rdy = 4'h0; m_brk = 1'b0; m_ext = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_cyc(3);
        n_cmp++; if (keyboard_code !== 8'h00) begin n_bad++; $display("FAIL reset_code got %h want 00", keyboard_code); end
        n_cmp++; if (code_rdy !== 8'h00) begin n_bad++; $display("FAIL reset_rdy got %h want 00", code_rdy); end
        n_cmp++; if (code_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", code_valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", frame_err); end
        reset_n = 1'b1;
        wait_cyc(4);
    endtask

    task automatic test_basic();
        // single 0x1C, latency from stop-bit fall: 2 sync + F filter + edge + register
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0); model_frame(8'h1C, 1'b1);
        n_cmp++; if (keyboard_code !== 8'h1C || code_rdy !== 8'h01) begin n_bad++; $display("FAIL basic_1c got %h/%h want 1c/01", keyboard_code, code_rdy); end
        n_cmp++; if (d_nvalid !== m_nvalid) begin n_bad++; $display("FAIL basic_1c_valid got %0d want %0d", d_nvalid, m_nvalid); end
        n_cmp++; if (last_valid_cyc - fall_cyc !== F + 3) begin n_bad++; $display("FAIL report_latency got %0d want %0d", last_valid_cyc - fall_cyc, F + 3); end
        // bad parity then 0x29
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0); model_frame(8'h1C, 1'b0);
        n_cmp++; if (keyboard_code !== 8'h1C || code_rdy !== 8'h09) begin n_bad++; $display("FAIL badpar got %h/%h want 1c/09", keyboard_code, code_rdy); end
        n_cmp++; if (d_nerr !== m_nerr || d_nvalid !== m_nvalid) begin n_bad++; $display("FAIL badpar_pulses got %0d/%0d want %0d/%0d", d_nvalid, d_nerr, m_nvalid, m_nerr); end
        send_frame(8'h29, 1'b0, 1'b0, 1'b0); model_frame(8'h29, 1'b1);
        n_cmp++; if (keyboard_code !== 8'h29 || code_rdy !== 8'h00) begin n_bad++; $display("FAIL after_err got %h/%h want 29/00", keyboard_code, code_rdy); end
        // bad stop bit
        send_frame(8'h33, 1'b0, 1'b1, 1'b0); model_frame(8'h33, 1'b0);
        n_cmp++; if (code_rdy !== {4'h0, m_rdy} || d_nerr !== m_nerr) begin n_bad++; $display("FAIL badstop got %h/%0d want %h/%0d", code_rdy, d_nerr, m_rdy, m_nerr); end
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = d_nvalid;
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0); model_frame(8'hF0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0); model_frame(8'h1C, 1'b1);
        n_cmp++; if (d_nvalid - v0 !== 1) begin n_bad++; $display("FAIL f0_1c_valid got %0d want 1", d_nvalid - v0); end
        n_cmp++; if (keyboard_code !== 8'h1C || code_rdy !== {4'h0, m_rdy} || code_rdy[1] !== 1'b1) begin n_bad++; $display("FAIL f0_1c got %h/%h want 1c/%h", keyboard_code, code_rdy, m_rdy); end
        v0 = d_nvalid;
        send_frame(8'hE0, 1'b0, 1'b0, 1'b0); model_frame(8'hE0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0); model_frame(8'hF0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b0, 1'b0); model_frame(8'h75, 1'b1);
        n_cmp++; if (d_nvalid - v0 !== 1) begin n_bad++; $display("FAIL e0f075_valid got %0d want 1", d_nvalid - v0); end
        n_cmp++; if (keyboard_code !== 8'h75 || code_rdy[2:1] !== 2'b11 || code_rdy !== {4'h0, m_rdy}) begin n_bad++; $display("FAIL e0f075 got %h/%h want 75/%h", keyboard_code, code_rdy, m_rdy); end
    endtask

    task automatic test_timeout();
        int e0, v0, lat;
        bit seen;
        e0 = d_nerr; v0 = d_nvalid;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
        seen = 1'b0;
        for (int i = 0; i < T + 200 && !seen; i++) begin
            wait_cyc(1);
            if (d_nerr != e0) seen = 1'b1;
        end
        wait_cyc(2);
        m_rdy[3] = 1'b1; m_nerr++;
        lat = last_err_cyc - fall_cyc;
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL timeout_seen got none want pulse"); end
        n_cmp++; if (lat !== F + 3 + T) begin n_bad++; $display("FAIL timeout_latency got %0d want %0d", lat, F + 3 + T); end
        n_cmp++; if (d_nerr - e0 !== 1 || d_nvalid !== v0 || code_rdy !== {4'h0, m_rdy}) begin n_bad++; $display("FAIL timeout_state got err %0d rdy %h want 1 %h", d_nerr - e0, code_rdy, m_rdy); end
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0); model_frame(8'h1C, 1'b1);
        n_cmp++; if (keyboard_code !== 8'h1C || code_rdy !== {4'h0, m_rdy}) begin n_bad++; $display("FAIL post_timeout got %h/%h want 1c/%h", keyboard_code, code_rdy, m_rdy); end
    endtask

    task automatic test_glitch_and_reset();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1); model_frame(8'h5A, 1'b1);
        n_cmp++; if (keyboard_code !== 8'h5A || code_rdy !== {4'h0, m_rdy} || d_nvalid !== m_nvalid) begin n_bad++; $display("FAIL glitch got %h/%h want 5a/%h", keyboard_code, code_rdy, m_rdy); end
        // partial frame, then reset in the middle of a low phase
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        ps2_clk = 1'b0;
        wait_cyc(4);
        reset_n = 1'b0;
        wait_cyc(2);
        n_cmp++; if (keyboard_code !== 8'h00 || code_rdy !== 8'h00 || code_valid !== 1'b0 || frame_err !== 1'b0) begin n_bad++; $display("FAIL midreset got %h/%h/%b/%b want zeros", keyboard_code, code_rdy, code_valid, frame_err); end
        ps2_clk = 1'b1;
        wait_cyc(2);
        reset_n = 1'b1;
        model_reset();
        wait_cyc(H);
        send_frame(8'h16, 1'b0, 1'b0, 1'b0); model_frame(8'h16, 1'b1);
        n_cmp++; if (keyboard_code !== 8'h16 || code_rdy !== 8'h01 || d_nerr !== m_nerr || d_nvalid !== m_nvalid) begin n_bad++; $display("FAIL after_reset got %h/%h err %0d want 16/01 err %0d", keyboard_code, code_rdy, d_nerr, m_nerr); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit bp, bs, gl;
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 5))
                0: b = 8'hF0;
                1: b = 8'hE0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            bp = ($urandom_range(0, 6) == 0);
            bs = ($urandom_range(0, 9) == 0);
            gl = ($urandom_range(0, 3) == 0);
            send_frame(b, bp, bs, gl);
            model_frame(b, !bp && !bs);
            n_cmp++;
            if (keyboard_code !== m_code || code_rdy !== {4'h0, m_rdy} ||
                d_nvalid !== m_nvalid || d_nerr !== m_nerr) begin
                n_bad++;
                $display("FAIL random[%0d] byte %h got %h/%h v%0d e%0d want %h/%h v%0d e%0d",
                         k, b, keyboard_code, code_rdy, d_nvalid, d_nerr,
                         m_code, m_rdy, m_nvalid, m_nerr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_glitch_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
